// File: rtl/instruction_loader_if.sv
// Byte-stream in / instruction-memory write out bundle for instruction_loader.
// slave = loader side, master = host / fetch-stage side.
interface instruction_loader_if #(
    parameter int CNT_W = 7
);
    logic             i_start;
    logic [7:0]       i_rx_data;
    logic             i_rx_valid;
    logic             o_we;
    logic [31:0]      o_instr_data;
    logic [CNT_W-1:0] o_word_count;
    logic             o_busy;
    logic             o_done;
    logic             o_error;

    modport slave (
        input  i_start, i_rx_data, i_rx_valid,
        output o_we, o_instr_data, o_word_count, o_busy, o_done, o_error
    );

    modport master (
        output i_start, i_rx_data, i_rx_valid,
        input  o_we, o_instr_data, o_word_count, o_busy, o_done, o_error
    );
endinterface

// File: rtl/instruction_loader.sv
// Assembles MSB-first program bytes into 32-bit words and writes them to instruction memory.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the HALT word.
module instruction_loader #(
    parameter int MEM_DEPTH = 64,
    parameter int CNT_W     = 7
) (
    input  logic                 clk,
    input  logic                 i_rst,
    instruction_loader_if.slave  bus
);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, RECV, DONE, ERROR, CKSUM} state_t;
`else
    typedef enum logic [2:0] {IDLE, RECV, DONE, ERROR} state_t;
`endif

    localparam logic [31:0] HALT = '1;

    state_t           state_q;
    logic [1:0]       byte_idx_q;
    logic [23:0]      shift_q;
    logic             we_q;
    logic [31:0]      instr_q;
    logic [CNT_W-1:0] count_q;
    logic             done_q;
    logic             error_q;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]       xor_q;
`else
    logic             halt_q;
`endif

    logic [31:0] word_d;
    logic        full_d;

    always_comb begin
        word_d = {shift_q, bus.i_rx_data};
        full_d = (count_q == CNT_W'(MEM_DEPTH));
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            byte_idx_q <= '0;
            shift_q    <= '0;
            we_q       <= 1'b0;
            instr_q    <= '0;
            count_q    <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            xor_q      <= '0;
`else
            halt_q     <= 1'b0;
`endif
        end else begin
            we_q <= 1'b0;
            case (state_q)
                IDLE, DONE, ERROR: begin
                    if (bus.i_start) begin
                        state_q    <= RECV;
                        byte_idx_q <= '0;
                        count_q    <= '0;
                        done_q     <= 1'b0;
                        error_q    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                        xor_q      <= '0;
`else
                        halt_q     <= 1'b0;
`endif
                    end
                end
                RECV: begin
`ifndef LOADER_CHECKSUM_EN
                    // HALT's write cycle has passed; close the session one edge later.
                    if (halt_q) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        halt_q  <= 1'b0;
                    end else
`endif
                    if (bus.i_rx_valid) begin
                        byte_idx_q <= byte_idx_q + 2'd1;
                        shift_q    <= {shift_q[15:0], bus.i_rx_data};
`ifdef LOADER_CHECKSUM_EN
                        xor_q      <= xor_q ^ bus.i_rx_data;
`endif
                        if (byte_idx_q == 2'd3) begin
                            if (full_d) begin
                                state_q <= ERROR;
                                error_q <= 1'b1;
                            end else begin
                                we_q    <= 1'b1;
                                instr_q <= word_d;
                                count_q <= count_q + CNT_W'(1);
                                if (word_d == HALT) begin
`ifdef LOADER_CHECKSUM_EN
                                    state_q <= CKSUM;
`else
                                    halt_q  <= 1'b1;
`endif
                                end
                            end
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                CKSUM: begin
                    if (bus.i_rx_valid) begin
                        if (bus.i_rx_data == xor_q) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ERROR;
                            error_q <= 1'b1;
                        end
                    end
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.o_we         = we_q;
    assign bus.o_instr_data = instr_q;
    assign bus.o_word_count = count_q;
`ifdef LOADER_CHECKSUM_EN
    assign bus.o_busy       = (state_q == RECV) || (state_q == CKSUM);
`else
    assign bus.o_busy       = (state_q == RECV);
`endif
    assign bus.o_done       = done_q;
    assign bus.o_error      = error_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Directed self-checking bench for instruction_loader: a 64-deep and a 4-deep instance
// share byte stimulus; i_start/i_rx_valid are steered to one instance at a time.
module tb_instruction_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = '0;
    logic       sel_a = 1'b1;
    logic [7:0] exp_xor = '0;
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;

    logic [31:0] wqa[$];
    int          wca[$];
    logic [31:0] wqb[$];

    instruction_loader_if #(.CNT_W(7)) ifa ();
    instruction_loader_if #(.CNT_W(3)) ifb ();

    assign ifa.i_start    = start & sel_a;
    assign ifa.i_rx_valid = rx_valid & sel_a;
    assign ifa.i_rx_data  = rx_data;
    assign ifb.i_start    = start & ~sel_a;
    assign ifb.i_rx_valid = rx_valid & ~sel_a;
    assign ifb.i_rx_data  = rx_data;

    instruction_loader #(.MEM_DEPTH(64), .CNT_W(7)) dut_a (.clk(clk), .i_rst(rst), .bus(ifa));
    instruction_loader #(.MEM_DEPTH(4),  .CNT_W(3)) dut_b (.clk(clk), .i_rst(rst), .bus(ifb));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ifa.o_we) begin
            wqa.push_back(ifa.o_instr_data);
            wca.push_back(cyc);
        end
        if (ifb.o_we) wqb.push_back(ifb.o_instr_data);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic do_start();
        @(negedge clk); start = 1'b1; rx_valid = 1'b0;
        @(negedge clk); start = 1'b0;
        exp_xor = '0;
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk); rx_valid = 1'b1; rx_data = b;
        exp_xor = exp_xor ^ b;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send(w[8*i +: 8]);
    endtask

    task automatic idle(input int n);
        @(negedge clk); rx_valid = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic close_ok();
`ifdef LOADER_CHECKSUM_EN
        send(exp_xor);
`endif
        idle(3);
    endtask

    initial begin
        int base;
        int s;

        // Reset state
        do_reset();
        check_eq("rst_we",    ifa.o_we, 0);
        check_eq("rst_data",  ifa.o_instr_data, 0);
        check_eq("rst_count", ifa.o_word_count, 0);
        check_eq("rst_busy",  ifa.o_busy, 0);
        check_eq("rst_done",  ifa.o_done, 0);
        check_eq("rst_error", ifa.o_error, 0);
        check_eq("rst_count_b", ifb.o_word_count, 0);

        // 88888888 then HALT, streamed back to back
        sel_a = 1'b1;
        do_start();
        check_eq("start_busy", ifa.o_busy, 1);
        base = wqa.size();
        send_word(32'h8888_8888);
        send_word(32'hFFFF_FFFF);
        close_ok();
        check_eq("s1_nwr",   wqa.size() - base, 2);
        check_eq("s1_w0",    wqa[base], 32'h8888_8888);
        check_eq("s1_w1",    wqa[base+1], 32'hFFFF_FFFF);
        check_eq("s1_count", ifa.o_word_count, 2);
        check_eq("s1_done",  ifa.o_done, 1);
        check_eq("s1_error", ifa.o_error, 0);
        check_eq("s1_busy",  ifa.o_busy, 0);

        // Bytes after the session are ignored
        base = wqa.size();
        repeat (4) send(8'h5A);
        idle(3);
        check_eq("ign_nwr",   wqa.size() - base, 0);
        check_eq("ign_count", ifa.o_word_count, 2);
        check_eq("ign_data",  ifa.o_instr_data, 32'hFFFF_FFFF);
        check_eq("ign_done",  ifa.o_done, 1);

        // Single A8 word: one pulse exactly one cycle after the fourth strobe
        do_start();
        check_eq("s2_done_clr",  ifa.o_done, 0);
        check_eq("s2_count_clr", ifa.o_word_count, 0);
        base = wqa.size();
        send_word(32'hA8A8_A8A8);
        s = cyc;
        idle(3);
        check_eq("s2_nwr",  wqa.size() - base, 1);
        check_eq("s2_data", wqa[base], 32'hA8A8_A8A8);
        check_eq("s2_lat",  wca[base], s + 1);

        // i_start mid-word does not restart the session
        send(8'h11); send(8'h22);
        idle(1);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        send(8'h33); send(8'h44);
        idle(2);
        check_eq("s2_nwr2",  wqa.size() - base, 2);
        check_eq("s2_w1",    wqa[wqa.size()-1], 32'h1122_3344);
        check_eq("s2_count", ifa.o_word_count, 2);
        check_eq("s2_busy",  ifa.o_busy, 1);
        send_word(32'hFFFF_FFFF);
        close_ok();
        check_eq("s2_count3", ifa.o_word_count, 3);
        check_eq("s2_done",   ifa.o_done, 1);

        // Reset mid-word, colliding with i_start and a byte strobe
        do_start();
        base = wqa.size();
        send(8'hAA); send(8'hBB);
        @(negedge clk); rst = 1'b1; start = 1'b1; rx_valid = 1'b1; rx_data = 8'hCC;
        @(negedge clk); start = 1'b0; rx_valid = 1'b0;
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        check_eq("mr_nwr",   wqa.size() - base, 0);
        check_eq("mr_busy",  ifa.o_busy, 0);
        check_eq("mr_count", ifa.o_word_count, 0);
        check_eq("mr_data",  ifa.o_instr_data, 0);
        check_eq("mr_done",  ifa.o_done, 0);
        do_start();
        send_word(32'h0000_FFFF);
        send_word(32'hFFFF_FFFF);
        close_ok();
        check_eq("mr_nwr2",  wqa.size() - base, 2);
        check_eq("mr_w0",    wqa[base], 32'h0000_FFFF);
        check_eq("mr_count2", ifa.o_word_count, 2);
        check_eq("mr_done2", ifa.o_done, 1);

        // Depth-4 instance: fifth word overflows
        sel_a = 1'b0;
        do_start();
        base = wqb.size();
        send_word(32'h0101_0101);
        send_word(32'h0202_0202);
        send_word(32'h0303_0303);
        send_word(32'h0404_0404);
        send_word(32'h0505_0505);
        idle(3);
        check_eq("ov_nwr",   wqb.size() - base, 4);
        check_eq("ov_last",  wqb[wqb.size()-1], 32'h0404_0404);
        check_eq("ov_hold",  ifb.o_instr_data, 32'h0404_0404);
        check_eq("ov_error", ifb.o_error, 1);
        check_eq("ov_done",  ifb.o_done, 0);
        check_eq("ov_count", ifb.o_word_count, 4);
        check_eq("ov_busy",  ifb.o_busy, 0);

        // HALT in the last slot is not an overflow
        do_start();
        check_eq("ls_err_clr", ifb.o_error, 0);
        base = wqb.size();
        send_word(32'h0A0B_0C0D);
        send_word(32'h1020_3040);
        send_word(32'h5060_7080);
        send_word(32'hFFFF_FFFF);
        close_ok();
        check_eq("ls_nwr",   wqb.size() - base, 4);
        check_eq("ls_last",  wqb[wqb.size()-1], 32'hFFFF_FFFF);
        check_eq("ls_done",  ifb.o_done, 1);
        check_eq("ls_error", ifb.o_error, 0);
        check_eq("ls_count", ifb.o_word_count, 4);

`ifdef LOADER_CHECKSUM_EN
        // 12^34^56^78 = 08, HALT bytes cancel
        sel_a = 1'b1;
        do_start();
        send_word(32'h1234_5678);
        send_word(32'hFFFF_FFFF);
        send(8'h08);
        idle(3);
        check_eq("ck_ok_done",  ifa.o_done, 1);
        check_eq("ck_ok_error", ifa.o_error, 0);
        do_start();
        send_word(32'h1234_5678);
        send_word(32'hFFFF_FFFF);
        send(8'h09);
        idle(3);
        check_eq("ck_bad_done",  ifa.o_done, 0);
        check_eq("ck_bad_error", ifa.o_error, 1);
        check_eq("ck_bad_count", ifa.o_word_count, 2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/instruction_loader.md
INSTRUCTION_LOADER -- requirements
Module: instruction_loader

Interface
REQ-001 Parameter MEM_DEPTH, default 64, meaning: instruction memory capacity in 32-bit words.
REQ-002 Parameter CNT_W, default 7, meaning: word counter width, SHALL equal clog2(MEM_DEPTH)+1.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 i_rst  input  1  reset, synchronous and active-high.
REQ-005 i_start  input  1  request to open a load session.
REQ-006 i_rx_data  input  8  incoming program byte.
REQ-007 i_rx_valid  input  1  i_rx_data valid this cycle; one-cycle strobe per byte, no backpressure.
REQ-008 o_we  output  1  write strobe to the fetch stage instruction memory.
REQ-009 o_instr_data  output  32  assembled instruction word; valid while o_we=1.
REQ-010 o_word_count  output  CNT_W  words written in the current session.
REQ-011 o_busy  output  1  session in progress.
REQ-012 o_done  output  1  session completed successfully; level, held until next session or reset.
REQ-013 o_error  output  1  session aborted (overflow or checksum); level, held until next session or reset.

Function
REQ-014 FSM states: IDLE, RECV, CKSUM, DONE, ERROR; o_busy=1 only in RECV and CKSUM.
REQ-015 IDLE/DONE/ERROR + i_start=1 -> RECV; byte index, o_word_count, o_done, o_error all cleared on that edge.
REQ-016 i_start while in RECV or CKSUM is ignored.
REQ-017 i_rx_valid outside RECV and CKSUM is ignored; no output changes.
REQ-018 In RECV, bytes assemble MSB first: first byte -> bits 31:24, fourth byte -> bits 7:0.
REQ-019 On the edge accepting the fourth byte, o_instr_data is loaded and o_we is asserted for exactly one cycle (visible the cycle after the fourth strobe).
REQ-020 o_word_count increments by 1 on the same edge that asserts o_we.
REQ-021 Byte strobes on consecutive cycles SHALL be accepted without loss, including a strobe in the o_we cycle.
REQ-022 A completed word equal to 32'hFFFFFFFF (HALT) is written like any other word, then the FSM leaves RECV (to CKSUM or DONE per REQ-030/031).
REQ-023 If o_word_count equals MEM_DEPTH when a further word completes, that word is not written (o_we stays 0) and the FSM goes to ERROR.
REQ-024 A HALT word arriving as word number MEM_DEPTH (last slot) is written and is not an overflow.
REQ-025 o_instr_data holds its last value when o_we=0.

Reset
REQ-026 i_rst=1 at a rising edge: FSM -> IDLE, o_we=0, o_instr_data=0, o_word_count=0, o_busy=0, o_done=0, o_error=0, byte index and checksum cleared.
REQ-027 Reset takes priority over i_start and i_rx_valid on the same edge.
REQ-028 Reset mid-session discards any partially assembled word; no o_we is generated for it.
REQ-029 o_word_count after reset counts from 0; no memory write is produced by reset itself.

Configuration
REQ-030 With LOADER_CHECKSUM_EN defined: a running XOR of every byte accepted in RECV is kept; after HALT the FSM enters CKSUM, the next accepted byte is compared to the XOR; match -> DONE, mismatch -> ERROR.
REQ-031 Without LOADER_CHECKSUM_EN: CKSUM state and XOR logic absent; FSM goes RECV -> DONE on the edge after the HALT word's o_we.

Verification
REQ-032 Reset, i_start, bytes 88 88 88 88 FF FF FF FF -> o_we pulses with 32'h88888888 then 32'hFFFFFFFF, o_word_count=2, o_done=1 (no checksum build).
REQ-033 Bytes A8 A8 A8 A8 streamed on four consecutive cycles -> single o_we pulse one cycle after fourth strobe, o_instr_data=32'hA8A8A8A8.
REQ-034 MEM_DEPTH=4, five non-HALT words -> four o_we pulses, fifth suppressed, o_error=1, o_word_count=4.
REQ-035 i_rst=1 after two bytes of a word, then new session with 00 00 FF FF FF FF FF FF -> first write 32'h0000FFFF, o_word_count=2, o_done=1.
REQ-036 LOADER_CHECKSUM_EN: words 32'h12345678, HALT, then checksum 08 -> o_done=1; same with checksum 09 -> o_error=1, o_done=0.
